// File: rtl/lc3_mem_responder.sv
// LC-3 memory-side responder: word RAM plus memory-mapped KBSR/KBDR/DSR/DDR/MCR,
// each access completing after WAIT_CYCLES wait states. Devices exist only with LC3_MEM_DEVICES_EN.
module lc3_mem_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MIO_EN,
  input  logic        R_W,
  input  logic [15:0] a,
  input  logic [15:0] d_in,
  output logic [15:0] d_out,
  output logic        R,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        kb_accept,
  output logic        dd_valid,
  output logic [7:0]  dd_data,
  input  logic        dd_ack,
  output logic        kb_irq,
  output logic        mcr_run
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        capture, enter_done;

  logic [15:0] a_p0, d_p0;
  logic        rw_p0;
  logic [15:0] acc_a, acc_d;
  logic        acc_rw;
  logic        wr_done, rd_done, ram_wr;
  logic [15:0] rd_data, ram_q;

  logic [15:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    capture    = 1'b0;
    enter_done = 1'b0;
    case (state)
      IDLE: begin
        if (MIO_EN) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt  = DONE;
            enter_done = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt  = DONE;
          enter_done = 1'b1;
          cnt_nxt    = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture stage: the request is frozen here so the bus may change mid-access
  always_ff @(posedge clk) begin
    if (capture) begin
      a_p0  <= a;
      rw_p0 <= R_W;
      d_p0  <= d_in;
    end
  end

  // With zero wait states the commit edge is the capture edge, so use the live bus
  assign acc_a   = (state == IDLE) ? a    : a_p0;
  assign acc_rw  = (state == IDLE) ? R_W  : rw_p0;
  assign acc_d   = (state == IDLE) ? d_in : d_p0;
  assign wr_done = enter_done &  acc_rw;
  assign rd_done = enter_done & ~acc_rw;

  assign ram_q = mem[acc_a[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (ram_wr) mem[acc_a[ADDR_W-1:0]] <= acc_d;
  end

  // Completion stage: registered ready pulse and read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      R     <= 1'b0;
      d_out <= 16'h0000;
    end else begin
      R <= enter_done;
      if (rd_done) d_out <= rd_data;
    end
  end

`ifdef LC3_MEM_DEVICES_EN
  logic       io_space, kbdr_rd, ddr_wr, kb_take;
  logic       kb_rdy, kb_ie, dsr_rdy, mcr_q;
  logic [7:0] kbdr;

  assign io_space = (acc_a[15:9] == 7'h7F);
  assign ram_wr   = wr_done & ~io_space;
  assign kbdr_rd  = rd_done & (acc_a == 16'hFE02);
  assign ddr_wr   = wr_done & (acc_a == 16'hFE06);
  // A KBDR read on the same edge defers the next capture by one edge
  assign kb_take  = kb_valid & ~kb_rdy & ~kbdr_rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kb_rdy    <= 1'b0;
      kb_ie     <= 1'b0;
      kbdr      <= 8'h00;
      kb_accept <= 1'b0;
      dsr_rdy   <= 1'b1;
      dd_valid  <= 1'b0;
      dd_data   <= 8'h00;
      mcr_q     <= 1'b1;
    end else begin
      kb_accept <= kb_take;
      if (kbdr_rd) begin
        kb_rdy <= 1'b0;
      end else if (kb_take) begin
        kb_rdy <= 1'b1;
        kbdr   <= kb_data;
      end
      if (wr_done && acc_a == 16'hFE00) kb_ie <= acc_d[14];
      if (wr_done && acc_a == 16'hFFFE) mcr_q <= acc_d[15];
      if (ddr_wr) begin
        dd_data  <= acc_d[7:0];
        dd_valid <= 1'b1;
        dsr_rdy  <= 1'b0;
      end else if (dd_ack && dd_valid) begin
        dd_valid <= 1'b0;
        dsr_rdy  <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = ram_q;
    if (io_space) begin
      rd_data = 16'h0000;
      case (acc_a)
        16'hFE00: rd_data = {kb_rdy, kb_ie, 14'h0000};
        16'hFE02: rd_data = {8'h00, kbdr};
        16'hFE04: rd_data = {dsr_rdy, 15'h0000};
        16'hFFFE: rd_data = {mcr_q, 15'h0000};
        default:  ;
      endcase
    end
  end

  assign kb_irq  = kb_rdy & kb_ie;
  assign mcr_run = mcr_q;
`else
  logic unused_inputs;

  assign ram_wr        = wr_done;
  assign rd_data       = ram_q;
  assign kb_accept     = 1'b0;
  assign dd_valid      = 1'b0;
  assign dd_data       = 8'h00;
  assign kb_irq        = 1'b0;
  assign mcr_run       = 1'b1;
  assign unused_inputs = ^{acc_a, kb_valid, kb_data, dd_ack};
`endif

endmodule

// File: doc/lc3_mem_responder.md
# lc3_mem_responder

Memory-side responder for the LC-3 datapath's memory bus. It accepts accesses driven from MAR (`a`), write data (`d_in`), `MIO_EN` and `R_W`. Each access completes after a fixed number of wait states, signalled by a one-cycle ready pulse `R`. It holds the word-addressed RAM and the LC-3 memory-mapped device registers (KBSR/KBDR/DSR/DDR/MCR), and sits opposite the datapath as the `memory` instance.

## Interface
- `ADDR_W`, 12: RAM index width; RAM depth is 2^ADDR_W 16-bit words.
- `WAIT_CYCLES`, 4: wait states per access; legal range 0..15.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `MIO_EN`  in  1  access request, held high by the datapath until `R` is seen.
- `R_W`  in  1  0 = read, 1 = write.
- `a`  in  16  word address.
- `d_in`  in  16  write data.
- `d_out`  out  16  read data.
- `R`  out  1  ready; one-cycle completion pulse.
- `kb_valid`  in  1  keyboard has a character.
- `kb_data`  in  8  keyboard character.
- `kb_accept`  out  1  one-cycle pulse: character captured.
- `dd_valid`  out  1  display character pending.
- `dd_data`  out  8  display character.
- `dd_ack`  in  1  display consumed the character.
- `kb_irq`  out  1  keyboard interrupt request, equal to KBSR[15] & KBSR[14].
- `mcr_run`  out  1  equals MCR[15]; the machine halts when it is 0.

## Operation
- FSM states: IDLE, WAIT, DONE.
- **Capture.** In IDLE with `MIO_EN`=1, capture `a`, `R_W` and `d_in`, load the counter with WAIT_CYCLES, and go to WAIT. If WAIT_CYCLES=0, go straight to DONE.
- **WAIT.** Decrement the counter each cycle. When it reaches 0, go to DONE.
- **DONE.** `R`=1 for exactly one cycle.
  - A write commits on the edge that enters DONE.
  - For a read, `d_out` loads on that same edge and holds until the next read completes.
  - The next state is always IDLE.
- **MIO_EN dropped mid-access.** The captured access still completes, including `R` and any write. Later changes to `a`, `R_W` or `d_in` are ignored until the next capture.
- **Address decode** (uses the captured address):
  - xFE00 KBSR: bit15 = ready (read-only), bit14 = IE (read/write), other bits read 0.
  - xFE02 KBDR: bits 7:0 = last character, bits 15:8 read 0. A read clears KBSR[15]. Writes are ignored.
  - xFE04 DSR: bit15 = display ready, other bits read 0. Writes are ignored.
  - xFE06 DDR: a write loads `dd_data` from `d_in[7:0]`, sets `dd_valid`, and clears DSR[15]. A read returns 0.
  - xFFFE MCR: bit15 is read/write, other bits read 0.
  - Any other address in xFE00..xFFFF reads 0 and ignores writes.
  - All remaining addresses go to RAM[`a`[ADDR_W-1:0]], aliasing modulo the RAM depth.
- **Keyboard.** When `kb_valid`=1 and KBSR[15]=0, capture `kb_data` into KBDR, set KBSR[15], and pulse `kb_accept` for one cycle.
- **Display.** When `dd_ack`=1 and `dd_valid`=1, clear `dd_valid` and set DSR[15].
- **Simultaneous events:**
  - KBDR read completing on the same edge as `kb_valid`: the read returns the old character and clears ready. The new character is captured on the following edge.
  - DDR write completing on the same edge as `dd_ack`: the write wins; `dd_valid` stays 1 with the new data.
  - DDR write while `dd_valid`=1: overwrites `dd_data`; `dd_valid` stays 1.

## Timing
- **Reset values:** FSM=IDLE, `R`=0, `d_out`=0, KBSR=0, KBDR=0, DSR=x8000, `dd_valid`=0, `dd_data`=0, MCR=x8000, `kb_accept`=0. Therefore `kb_irq`=0 and `mcr_run`=1.
- RAM contents are not reset.
- Reset asserted mid-access aborts the access; a pending write is discarded.
- **Latency:** with the capture edge at cycle 0, `R`=1 during cycle WAIT_CYCLES+1.
- **Back-to-back accesses:** if `MIO_EN` is still 1 in the IDLE cycle after DONE, a new capture occurs. Minimum access period is WAIT_CYCLES+2 cycles.
- `d_out` and `R` are registered outputs; there are no combinational paths from inputs to outputs.

## Configuration
- `LC3_MEM_DEVICES_EN` defined: the device registers and decode are as specified above.
- Undefined:
  - All 64K addresses map to RAM (modulo depth).
  - `kb_accept`=0, `dd_valid`=0, `dd_data`=0, `kb_irq`=0, `mcr_run`=1 constantly.
  - `kb_valid`, `kb_data` and `dd_ack` are ignored.

## Test plan
- **Reset state.** Hold `reset`=0 mid-write to x3000, then release and read x3000 -> the old value is returned, `R`=0 during reset, `mcr_run`=1.
- **Write/read latency.** Write x1234 to x3005 with WAIT_CYCLES=4 -> `R` pulses once, 5 cycles after capture. Read x3005 -> `d_out`=x1234 while `R`=1.
- **Aliasing and early drop.** With ADDR_W=12, write xBEEF to x0010, read x1010 -> xBEEF. A second write with `MIO_EN` dropped after the capture cycle still completes and commits.
- **Keyboard path.** Pulse `kb_valid` with x41 -> `kb_accept` pulses once, KBSR reads x8000. Write x4000 to KBSR -> `kb_irq`=1. Read KBDR -> x0041 and `kb_irq` falls.
- **Display path.** Write x0058 to DDR -> `dd_valid`=1, `dd_data`=x58, DSR reads x0000. Apply `dd_ack` -> DSR reads x8000. Apply `dd_ack` on the same edge as a second DDR write -> `dd_valid` stays 1.
- **MCR and macro.** Write x0000 to MCR -> `mcr_run`=0. With `LC3_MEM_DEVICES_EN` undefined, a write to xFE06 lands in RAM and reads back.
